// File: rtl/uart_dmi_bridge.sv
// uart_dmi_bridge
//   Sits between the UART byte FIFOs and a DMI master port. Collects a
//   7-byte request frame (HEADER, CMD, ADDR, D0..D3), issues one DMI request,
//   waits for the response and sends a 5-byte reply (status, data LE).
//
// Ports
//   CLK_I, RST_I             clock, async active-high reset
//   UART_RE_O/DREC_I/        RX FIFO read strobe, head byte, empty flag
//   UART_RX_EMPTY_I
//   UART_WE_O/DSEND_O/       TX start strobe, TX byte, transmitter idle
//   UART_TX_READY_I
//   DMI_REQ_*                request channel (valid/ready, addr, data, op)
//   DMI_RESP_*               response channel (valid/ready, data, status)
//   ERR_O                    one-cycle pulse when a frame is dropped
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | hunting for HEADER, other bytes discarded
// RX_CMD    | expecting command byte (01 read, 02 write)
// RX_ADDR   | expecting address byte
// RX_DATA   | collecting 4 data bytes, LSB first
// REQ       | DMI request presented, waiting for ready
// WAIT_RESP | waiting for DMI response
// TX_BYTE   | waiting for transmitter idle, then strobe one byte
// TX_WAIT   | guard cycle while the UART busy flag catches up
module uart_dmi_bridge #(
  parameter int          ADDR_W         = 7,
  parameter logic [7:0]  HEADER         = 8'h01,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  output logic              UART_RE_O,
  input  logic [7:0]        UART_DREC_I,
  input  logic              UART_RX_EMPTY_I,
  output logic              UART_WE_O,
  output logic [7:0]        UART_DSEND_O,
  input  logic              UART_TX_READY_I,
  output logic              DMI_REQ_VALID_O,
  input  logic              DMI_REQ_READY_I,
  output logic [ADDR_W-1:0] DMI_REQ_ADDR_O,
  output logic [31:0]       DMI_REQ_DATA_O,
  output logic [1:0]        DMI_REQ_OP_O,
  input  logic              DMI_RESP_VALID_I,
  output logic              DMI_RESP_READY_O,
  input  logic [31:0]       DMI_RESP_DATA_I,
  input  logic [1:0]        DMI_RESP_OP_I,
  output logic              ERR_O
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_CMD, S_RX_ADDR, S_RX_DATA,
    S_REQ, S_WAIT_RESP, S_TX_BYTE, S_TX_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        byte_idx_q;
  logic [2:0]        tx_idx_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        status_q;
  logic [31:0]       resp_q;
  logic              err_q;

  logic       rd;
  logic       rx_phase;
  logic       to_phase;
  logic       to_expire;
  logic       cmd_ok;
  logic       err_d;
  logic       we;
  logic [7:0] tx_byte;

  assign rx_phase  = (state_q == S_IDLE) || (state_q == S_RX_CMD) ||
                     (state_q == S_RX_ADDR) || (state_q == S_RX_DATA);
  assign to_phase  = (state_q == S_RX_CMD) || (state_q == S_RX_ADDR) ||
                     (state_q == S_RX_DATA);
  // Reset gating keeps the strobe low while reset is held even though IDLE
  // would otherwise read a non-empty FIFO.
  assign rd        = rx_phase && !UART_RX_EMPTY_I && !RST_I;
  // A byte consumed in the terminal cycle takes priority over the timeout.
  assign to_expire = to_phase && !rd && (to_cnt_q == '0);
  assign cmd_ok    = (UART_DREC_I == 8'h01) || (UART_DREC_I == 8'h02);

  always_comb begin
    case (tx_idx_q)
      3'd0:    tx_byte = {6'b0, status_q};
      3'd1:    tx_byte = resp_q[7:0];
      3'd2:    tx_byte = resp_q[15:8];
      3'd3:    tx_byte = resp_q[23:16];
      3'd4:    tx_byte = resp_q[31:24];
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    err_d            = 1'b0;
    we               = 1'b0;
    DMI_REQ_VALID_O  = 1'b0;
    DMI_RESP_READY_O = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd && UART_DREC_I == HEADER) state_d = S_RX_CMD;
      end
      S_RX_CMD: begin
        if (rd) begin
          if (cmd_ok) begin
            state_d = S_RX_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RX_ADDR: begin
        if (rd) begin
          state_d = S_RX_DATA;
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RX_DATA: begin
        if (rd) begin
          if (byte_idx_q == 2'd3) state_d = S_REQ;
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        DMI_REQ_VALID_O = 1'b1;
        if (DMI_REQ_READY_I) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        DMI_RESP_READY_O = 1'b1;
        if (DMI_RESP_VALID_I) state_d = S_TX_BYTE;
      end
      S_TX_BYTE: begin
        if (UART_TX_READY_I) begin
          we      = 1'b1;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (tx_idx_q == 3'd4) state_d = S_IDLE;
        else                  state_d = S_TX_BYTE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      byte_idx_q <= '0;
      tx_idx_q   <= '0;
      to_cnt_q   <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      status_q   <= '0;
      resp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;

      // Down-counter reloads on every consumed byte, which also covers the
      // HEADER byte that enters RX_CMD.
      if (rd)
        to_cnt_q <= TO_LOAD;
      else if (to_phase && to_cnt_q != '0)
        to_cnt_q <= to_cnt_q - 1'b1;

      if (rd) begin
        case (state_q)
          S_RX_CMD:  if (cmd_ok) op_q <= UART_DREC_I[1:0];
          S_RX_ADDR: begin
            addr_q     <= UART_DREC_I[ADDR_W-1:0];
            byte_idx_q <= '0;
          end
          S_RX_DATA: begin
            data_q[byte_idx_q*8 +: 8] <= UART_DREC_I;
            byte_idx_q                <= byte_idx_q + 1'b1;
          end
          default: ;
        endcase
      end

      if (state_q == S_WAIT_RESP && DMI_RESP_VALID_I) begin
        status_q <= DMI_RESP_OP_I;
        resp_q   <= DMI_RESP_DATA_I;
        tx_idx_q <= '0;
      end

      if (state_q == S_TX_WAIT) tx_idx_q <= tx_idx_q + 1'b1;
    end
  end

  assign UART_RE_O      = rd;
  assign UART_WE_O      = we;
  assign UART_DSEND_O   = we ? tx_byte : 8'h00;
  assign DMI_REQ_ADDR_O = addr_q;
  assign DMI_REQ_DATA_O = data_q;
  assign DMI_REQ_OP_O   = op_q;
  assign ERR_O          = err_q;

endmodule

// File: tb/tb_uart_dmi_bridge.sv
module tb_uart_dmi_bridge;

  localparam int ADDR_W = 7;

  logic              CLK_I = 1'b0;
  logic              RST_I;
  logic              UART_RE_O;
  logic [7:0]        UART_DREC_I;
  logic              UART_RX_EMPTY_I;
  logic              UART_WE_O;
  logic [7:0]        UART_DSEND_O;
  logic              UART_TX_READY_I;
  logic              DMI_REQ_VALID_O;
  logic              DMI_REQ_READY_I;
  logic [ADDR_W-1:0] DMI_REQ_ADDR_O;
  logic [31:0]       DMI_REQ_DATA_O;
  logic [1:0]        DMI_REQ_OP_O;
  logic              DMI_RESP_VALID_I;
  logic              DMI_RESP_READY_O;
  logic [31:0]       DMI_RESP_DATA_I;
  logic [1:0]        DMI_RESP_OP_I;
  logic              ERR_O;

  uart_dmi_bridge #(.ADDR_W(ADDR_W), .HEADER(8'h01), .TIMEOUT_CYCLES(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .UART_RE_O(UART_RE_O), .UART_DREC_I(UART_DREC_I), .UART_RX_EMPTY_I(UART_RX_EMPTY_I),
    .UART_WE_O(UART_WE_O), .UART_DSEND_O(UART_DSEND_O), .UART_TX_READY_I(UART_TX_READY_I),
    .DMI_REQ_VALID_O(DMI_REQ_VALID_O), .DMI_REQ_READY_I(DMI_REQ_READY_I),
    .DMI_REQ_ADDR_O(DMI_REQ_ADDR_O), .DMI_REQ_DATA_O(DMI_REQ_DATA_O), .DMI_REQ_OP_O(DMI_REQ_OP_O),
    .DMI_RESP_VALID_I(DMI_RESP_VALID_I), .DMI_RESP_READY_O(DMI_RESP_READY_O),
    .DMI_RESP_DATA_I(DMI_RESP_DATA_I), .DMI_RESP_OP_I(DMI_RESP_OP_I),
    .ERR_O(ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [55:0] frame;     // first byte in the top lane
    logic [7:0]  stall;     // cycles DMI ready is held low
    logic [1:0]  rsp_op;
    logic [31:0] rsp_data;
    logic [1:0]  exp_op;
    logic [6:0]  exp_addr;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [39:0] exp_tx;    // first reply byte in the top lane
  } vec_t;

  vec_t vecs [4];

  int n_cmp = 0;
  int n_fail = 0;

  // environment models
  logic [7:0]  rxq[$];
  int          tx_busy = 0;
  int          stall_cnt = 0;
  logic [1:0]  rsp_op_cfg = 2'd0;
  logic [31:0] rsp_data_cfg = 32'h0;

  // monitor state (written only by the monitor)
  int          err_cnt = 0;
  int          req_cnt = 0;
  int          stab_viol = 0;
  int          we_consec = 0;
  logic [7:0]  tx_log[$];
  logic [1:0]  last_op;
  logic [6:0]  last_addr;
  logic [31:0] last_data;
  logic        prev_valid = 1'b0;
  logic        prev_we = 1'b0;
  logic [40:0] prev_fields = '0;

  always @(negedge CLK_I) begin
    if (ERR_O) err_cnt++;
    if (DMI_REQ_VALID_O && DMI_REQ_READY_I) begin
      req_cnt++;
      last_op   = DMI_REQ_OP_O;
      last_addr = DMI_REQ_ADDR_O;
      last_data = DMI_REQ_DATA_O;
    end
    if (DMI_REQ_VALID_O && prev_valid &&
        ({DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O} != prev_fields))
      stab_viol++;
    prev_valid  = DMI_REQ_VALID_O;
    prev_fields = {DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O};
    if (UART_WE_O) begin
      tx_log.push_back(UART_DSEND_O);
      if (prev_we) we_consec++;
    end
    prev_we = UART_WE_O;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_rx();
    UART_RX_EMPTY_I = (rxq.size() == 0);
    UART_DREC_I     = UART_RX_EMPTY_I ? 8'h00 : rxq[0];
  endtask

  // One clock: sample strobes before the edge updates, then drive inputs.
  task automatic step();
    logic p;
    logic w;
    @(posedge CLK_I);
    p = UART_RE_O;
    w = UART_WE_O;
    #1;
    if (p && rxq.size() > 0) void'(rxq.pop_front());
    refresh_rx();
    if (w) tx_busy = 3;
    else if (tx_busy > 0) tx_busy--;
    UART_TX_READY_I = (tx_busy == 0);
    if (DMI_REQ_VALID_O) begin
      if (stall_cnt == 0) DMI_REQ_READY_I = 1'b1;
      else begin
        DMI_REQ_READY_I = 1'b0;
        stall_cnt--;
      end
    end else begin
      DMI_REQ_READY_I = 1'b0;
    end
    // Response is always valid; a decoy is shown until the bridge is ready.
    DMI_RESP_VALID_I = 1'b1;
    DMI_RESP_DATA_I  = DMI_RESP_READY_O ? rsp_data_cfg : 32'hBAD0_BAD0;
    DMI_RESP_OP_I    = DMI_RESP_READY_O ? rsp_op_cfg   : 2'd3;
  endtask

  task automatic wait_tx(input int target, input string name);
    int guard;
    guard = 0;
    while (tx_log.size() < target && guard < 300) begin
      step();
      guard++;
    end
    check({name, " reply bytes"}, 64'(tx_log.size()), 64'(target));
  endtask

  task automatic run_vector(input int i);
    vec_t v;
    int b_tx, b_req, b_err;
    v = vecs[i];
    b_tx = tx_log.size(); b_req = req_cnt; b_err = err_cnt;
    stall_cnt    = v.stall;
    rsp_op_cfg   = v.rsp_op;
    rsp_data_cfg = v.rsp_data;
    for (int b = 0; b < 7; b++) rxq.push_back(v.frame[55-8*b -: 8]);
    refresh_rx();
    wait_tx(b_tx + 5, $sformatf("v%0d", i));
    repeat (4) step();
    check($sformatf("v%0d req count", i), 64'(req_cnt - b_req), 64'd1);
    check($sformatf("v%0d op", i), 64'(last_op), 64'(v.exp_op));
    check($sformatf("v%0d addr", i), 64'(last_addr), 64'(v.exp_addr));
    if (v.chk_data) check($sformatf("v%0d data", i), 64'(last_data), 64'(v.exp_data));
    if (tx_log.size() >= b_tx + 5)
      for (int k = 0; k < 5; k++)
        check($sformatf("v%0d tx%0d", i, k), 64'(tx_log[b_tx+k]), 64'(v.exp_tx[39-8*k -: 8]));
    check($sformatf("v%0d err", i), 64'(err_cnt - b_err), 64'd0);
  endtask

  initial begin
    int b_tx, b_req, b_err;

    vecs[0] = '{frame: 56'h01_02_05_EF_BE_AD_DE, stall: 8'd0, rsp_op: 2'd0, rsp_data: 32'h0,
                exp_op: 2'd2, exp_addr: 7'h05, chk_data: 1'b1, exp_data: 32'hDEADBEEF,
                exp_tx: 40'h00_00_00_00_00};
    vecs[1] = '{frame: 56'h01_01_10_00_00_00_00, stall: 8'd5, rsp_op: 2'd0, rsp_data: 32'h12345678,
                exp_op: 2'd1, exp_addr: 7'h10, chk_data: 1'b0, exp_data: 32'h0,
                exp_tx: 40'h00_78_56_34_12};
    vecs[2] = '{frame: 56'h01_02_FF_01_02_03_04, stall: 8'd1, rsp_op: 2'd2, rsp_data: 32'hCAFEF00D,
                exp_op: 2'd2, exp_addr: 7'h7F, chk_data: 1'b1, exp_data: 32'h04030201,
                exp_tx: 40'h02_0D_F0_FE_CA};
    vecs[3] = '{frame: 56'h01_01_83_AA_BB_CC_DD, stall: 8'd0, rsp_op: 2'd3, rsp_data: 32'h00000001,
                exp_op: 2'd1, exp_addr: 7'h03, chk_data: 1'b0, exp_data: 32'h0,
                exp_tx: 40'h03_01_00_00_00};

    RST_I = 1'b1;
    UART_TX_READY_I  = 1'b1;
    DMI_REQ_READY_I  = 1'b0;
    DMI_RESP_VALID_I = 1'b0;
    DMI_RESP_DATA_I  = 32'h0;
    DMI_RESP_OP_I    = 2'd0;
    rxq.push_back(8'h5A);
    refresh_rx();
    #2;
    check("reset RE gated", 64'(UART_RE_O), 64'd0);
    check("reset outputs", 64'({UART_WE_O, UART_DSEND_O, DMI_REQ_VALID_O, DMI_REQ_ADDR_O,
                                 DMI_REQ_DATA_O, DMI_REQ_OP_O, DMI_RESP_READY_O, ERR_O}), 64'd0);
    repeat (3) step();
    RST_I = 1'b0;
    b_err = err_cnt;
    repeat (4) step();
    check("garbage after reset consumed", 64'(rxq.size()), 64'd0);
    check("garbage after reset no err", 64'(err_cnt - b_err), 64'd0);

    for (int i = 0; i < 4; i++) run_vector(i);

    // leading garbage, then a read frame to address 3
    b_tx = tx_log.size(); b_req = req_cnt; b_err = err_cnt;
    rsp_op_cfg = 2'd0; rsp_data_cfg = 32'h0000_00A5; stall_cnt = 0;
    foreach (vecs[0].frame[i]) ;
    rxq.push_back(8'hAA); rxq.push_back(8'h55); rxq.push_back(8'h01); rxq.push_back(8'h01);
    rxq.push_back(8'h03);
    for (int k = 0; k < 4; k++) rxq.push_back(8'h00);
    refresh_rx();
    wait_tx(b_tx + 5, "garbage");
    repeat (4) step();
    check("garbage req count", 64'(req_cnt - b_req), 64'd1);
    check("garbage addr", 64'(last_addr), 64'h03);
    check("garbage err", 64'(err_cnt - b_err), 64'd0);
    if (tx_log.size() >= b_tx + 2) check("garbage tx1", 64'(tx_log[b_tx+1]), 64'hA5);

    // bad command
    b_req = req_cnt; b_err = err_cnt;
    rxq.push_back(8'h01); rxq.push_back(8'h07);
    refresh_rx();
    repeat (6) step();
    check("badcmd err", 64'(err_cnt - b_err), 64'd1);
    check("badcmd no req", 64'(req_cnt - b_req), 64'd0);
    check("badcmd consumed", 64'(rxq.size()), 64'd0);
    run_vector(0);

    // inter-byte timeout after 01 02
    b_req = req_cnt; b_err = err_cnt;
    rxq.push_back(8'h01); rxq.push_back(8'h02);
    refresh_rx();
    step(); step();
    check("timeout bytes consumed", 64'(rxq.size()), 64'd0);
    repeat (15) step();
    @(negedge CLK_I); #1;
    check("timeout not early", 64'(err_cnt - b_err), 64'd0);
    step(); step();
    check("timeout pulse", 64'(err_cnt - b_err), 64'd1);
    rxq.push_back(8'h05);
    refresh_rx();
    repeat (6) step();
    check("late byte consumed", 64'(rxq.size()), 64'd0);
    check("late byte no err", 64'(err_cnt - b_err), 64'd1);
    check("timeout no req", 64'(req_cnt - b_req), 64'd0);
    run_vector(2);

    // reset in the middle of a reply
    b_tx = tx_log.size();
    stall_cnt = 0; rsp_op_cfg = vecs[3].rsp_op; rsp_data_cfg = vecs[3].rsp_data;
    for (int b = 0; b < 7; b++) rxq.push_back(vecs[3].frame[55-8*b -: 8]);
    refresh_rx();
    wait_tx(b_tx + 2, "pre-reset");
    RST_I = 1'b1;
    rxq.push_back(8'h77);
    refresh_rx();
    #1;
    check("midtx reset RE", 64'(UART_RE_O), 64'd0);
    check("midtx reset outputs", 64'({UART_WE_O, UART_DSEND_O, DMI_REQ_VALID_O, DMI_REQ_ADDR_O,
                                      DMI_REQ_DATA_O, DMI_REQ_OP_O, DMI_RESP_READY_O, ERR_O}), 64'd0);
    repeat (2) step();
    RST_I = 1'b0;
    b_tx = tx_log.size();
    repeat (12) step();
    check("post-reset no tx", 64'(tx_log.size() - b_tx), 64'd0);
    check("post-reset 77 consumed", 64'(rxq.size()), 64'd0);
    run_vector(1);

    check("req fields stable while stalled", 64'(stab_viol), 64'd0);
    check("no back-to-back WE", 64'(we_consec), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_dmi_bridge.md
Name: uart_dmi_bridge

Overview:
Protocol stage directly downstream of the UART interface. Pulls request frames byte-by-byte from the UART RX FIFO, converts each frame into one DMI request, waits for the DMI response, and serialises a 5-byte reply back through the UART TX path. It is the only consumer of the UART read port and the only producer on its write port.

Parameters:
ADDR_W, 7, DMI address width; must be ≤ 8; taken from the low bits of the address byte.
HEADER, 8'h01, frame start byte.
TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one frame before the frame is aborted.

Ports:
CLK_I  in  1  clock.
RST_I  in  1  asynchronous reset, active-high.
UART_RE_O  out  1  read strobe to UART; head data is valid in the same cycle.
UART_DREC_I  in  8  UART RX data; sampled only while UART_RE_O=1.
UART_RX_EMPTY_I  in  1  UART RX FIFO empty.
UART_WE_O  out  1  one-cycle TX start strobe.
UART_DSEND_O  out  8  TX byte; valid while UART_WE_O=1.
UART_TX_READY_I  in  1  UART transmitter idle.
DMI_REQ_VALID_O  out  1  request valid.
DMI_REQ_READY_I  in  1  request accepted.
DMI_REQ_ADDR_O  out  ADDR_W  request address.
DMI_REQ_DATA_O  out  32  write data.
DMI_REQ_OP_O  out  2  1=read, 2=write.
DMI_RESP_VALID_I  in  1  response valid.
DMI_RESP_READY_O  out  1  response accept.
DMI_RESP_DATA_I  in  32  response data.
DMI_RESP_OP_I  in  2  response status (0=ok, 2=fail, 3=busy).
ERR_O  out  1  one-cycle pulse on dropped frame (bad command or timeout).

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; byte counter, timeout counter, and request/response registers cleared. The UART FIFO contents are not touched.
- Request frame layout: HEADER, CMD, ADDR, D0, D1, D2, D3 (data little-endian, D0 = bits 7:0). CMD is 8'h01 for read or 8'h02 for write. Read frames still carry 4 data bytes, which are ignored.
- Read rule: UART_RE_O = (state is IDLE/RX_CMD/RX_ADDR/RX_DATA) && !UART_RX_EMPTY_I, generated combinationally. The byte is captured at the same clock edge. At most 1 byte is consumed per cycle.
- IDLE: a consumed byte equal to HEADER moves to RX_CMD. Any other byte is silently discarded, with no ERR_O.
- RX_CMD: a byte of 01 or 02 latches the op and moves to RX_ADDR. Any other value pulses ERR_O and returns to IDLE.
- RX_ADDR: latches addr = byte[ADDR_W-1:0] and moves to RX_DATA with the byte index set to 0.
- RX_DATA: stores the byte into lane idx. When idx=3 the state moves to REQ; otherwise idx is incremented.
- Timeout: a counter runs only in RX_CMD/RX_ADDR/RX_DATA. It clears on every consumed byte and on entering RX_CMD. When it reaches TIMEOUT_CYCLES-1 with no byte consumed, ERR_O pulses, the state returns to IDLE, and the partial frame is discarded. A byte consumed in that same cycle wins, and no timeout occurs.
- REQ: DMI_REQ_VALID_O=1, with addr/data/op held stable. On VALID && READY the state moves to WAIT_RESP. The minimum latency from the last frame byte to VALID is 1 cycle.
- WAIT_RESP: DMI_RESP_READY_O=1. On DMI_RESP_VALID_I the block latches the status and data, then moves to TX_BYTE with tx index 0. A response arriving while in REQ is ignored: RESP_READY is 0 there.
- Reply frame: byte0 = {6'b0, status}, bytes 1..4 = response data little-endian. A reply is sent for both reads and writes.
- TX_BYTE: when UART_TX_READY_I=1, the block asserts UART_WE_O for exactly 1 cycle with the current byte and moves to TX_WAIT.
- TX_WAIT: a single guard cycle, needed because the UART busy flag updates one cycle after the strobe. It then returns to TX_BYTE with idx+1, or to IDLE after byte 4.
- UART_WE_O is never asserted on two consecutive cycles.
- No RX bytes are consumed from REQ through the end of TX. Bytes arriving meanwhile stay in the UART FIFO.

Test Plan:
- Write frame 01 02 05 EF BE AD DE: DMI_REQ_OP_O=2, DMI_REQ_ADDR_O=7'h05, DMI_REQ_DATA_O=32'hDEADBEEF. Responding with op=0, data=0 must produce TX bytes 00 00 00 00 00 and return to IDLE.
- Read frame 01 01 10 00 00 00 00, with DMI_REQ_READY_I held low for 5 cycles: VALID is held with stable fields. Responding with op=0, data=32'h12345678 must produce TX 00 78 56 34 12.
- Garbage then frame: AA 55 01 01 03 00 00 00 00 produces exactly one DMI request with addr=3 and no ERR_O pulse.
- Bad command 01 07: ERR_O pulses once, and no DMI request is issued. A following valid frame is processed normally.
- Timeout with TIMEOUT_CYCLES=16: send 01 02, then starve the RX for 16 cycles. ERR_O pulses and the state returns to IDLE. A late byte 05 is then discarded as a non-header byte.
- Reset asserted mid-TX after 2 reply bytes: all outputs go to 0 immediately. After release, a new full frame produces a correct request and a 5-byte reply.
